// File: rtl/kgp_pkg.sv
// Shared types and constants for the KGP mini-RISC single-cycle datapath.
// Optional variable shifts in kgp_alu are enabled by DP_VAR_SHIFT_EN.
package kgp_pkg;

    localparam int XLEN   = 32;
    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int SH_LSB  = 11;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_COMP  = 4'd1,
        ALU_AND   = 4'd2,
        ALU_XOR   = 4'd3,
        ALU_SHLL  = 4'd4,
        ALU_SHRL  = 4'd5,
        ALU_SHRA  = 4'd6,
        ALU_SHLLV = 4'd7,
        ALU_SHRLV = 4'd8,
        ALU_SHRAV = 4'd9
    } alu_op_e;

    typedef enum logic [4:0] {
        BR_NONE = 5'd0,
        BR_B    = 5'd1,
        BR_BR   = 5'd2,
        BR_BLTZ = 5'd3,
        BR_BZ   = 5'd4,
        BR_BNZ  = 5'd5,
        BR_BL   = 5'd6,
        BR_BCY  = 5'd7,
        BR_BNCY = 5'd8
    } br_op_e;

    typedef enum logic [1:0] {
        RW_NONE = 2'd0,
        RW_RS   = 2'd1,
        RW_RT   = 2'd2,
        RW_R31  = 2'd3
    } reg_write_e;

    typedef enum logic [1:0] {
        WB_PC1  = 2'd0,
        WB_MEM  = 2'd1,
        WB_ALU  = 2'd2,
        WB_ZERO = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/kgp_alu.sv
// KGP ALU: add with carry, negate, logic ops and shifts.
// Register-amount shifts (alu_op 7-9) exist only with DP_VAR_SHIFT_EN.
module kgp_alu
    import kgp_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [4:0]      shamt_i,
    input  logic [3:0]      alu_op_i,
    output logic [XLEN-1:0] result_o,
    output logic            carry_o
);

    logic [XLEN:0] sum;

    assign sum = {1'b0, a_i} + {1'b0, b_i};

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (alu_op_i)
            ALU_ADD: begin
                result_o = sum[XLEN-1:0];
                carry_o  = sum[XLEN];
            end
            ALU_COMP:  result_o = (~b_i) + 32'd1;
            ALU_AND:   result_o = a_i & b_i;
            ALU_XOR:   result_o = a_i ^ b_i;
            ALU_SHLL:  result_o = a_i << shamt_i;
            ALU_SHRL:  result_o = a_i >> shamt_i;
            ALU_SHRA:  result_o = $unsigned($signed(a_i) >>> shamt_i);
`ifdef DP_VAR_SHIFT_EN
            ALU_SHLLV: result_o = a_i << b_i[4:0];
            ALU_SHRLV: result_o = a_i >> b_i[4:0];
            ALU_SHRAV: result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
`endif
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/kgp_data_path.sv
// KGP single-cycle datapath: PC, ROM, register file, ALU, data RAM, branches.
// Define DP_VAR_SHIFT_EN to build the register-amount shifts into kgp_alu.
module kgp_data_path
    import kgp_pkg::*;
#(
    parameter int    IMEM_DEPTH = 1024,
    parameter int    DMEM_DEPTH = 1024,
    parameter string IMEM_INIT  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  reg_write,
    input  logic        imm_mux_ctrl,
    input  logic        alu_mux_ctrl,
    input  logic [3:0]  alu_op,
    input  logic        dmem_enable,
    input  logic        dmem_write_enable,
    input  logic [1:0]  reg_write_mux_ctrl,
    input  logic [4:0]  br_op,
    output logic [31:0] instr_out,
    output logic [5:0]  opcode_out,
    output logic [5:0]  func_out,
    output logic [31:0] res_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] imm_res_out
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [XLEN-1:0] imem   [IMEM_DEPTH];
    logic [XLEN-1:0] dmem_q [DMEM_DEPTH];
    logic [XLEN-1:0] rf_q   [32];
    logic [IAW-1:0]  pc_q, pc_d, pc_inc;
    logic            carry_q, carry_d;

    logic [4:0]      rs, rt, shamt, wr_addr;
    logic [XLEN-1:0] rs_data, rt_data, alu_b, dmem_rdata;
    logic [DAW-1:0]  dmem_addr;
    logic            alu_carry;

    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = '0;
    end

    assign instr_out  = imem[pc_q];
    assign opcode_out = instr_out[31:OPC_LSB];
    assign func_out   = instr_out[5:0];
    assign rs         = instr_out[RS_LSB+:5];
    assign rt         = instr_out[RT_LSB+:5];
    assign shamt      = instr_out[SH_LSB+:5];
    assign rs_data    = rf_q[rs];
    assign rt_data    = rf_q[rt];

    assign imm_res_out = imm_mux_ctrl
        ? {{16{instr_out[15]}}, instr_out[15:0]}
        : {{11{instr_out[20]}}, instr_out[20:0]};
    assign alu_b = alu_mux_ctrl ? imm_res_out : rt_data;

    kgp_alu u_alu (
        .a_i      (rs_data),
        .b_i      (alu_b),
        .shamt_i  (shamt),
        .alu_op_i (alu_op),
        .result_o (alu_res_out),
        .carry_o  (alu_carry)
    );

    assign dmem_addr  = alu_res_out[DAW-1:0];
    assign dmem_rdata = dmem_enable ? dmem_q[dmem_addr] : '0;
    assign pc_inc     = pc_q + 1'b1;

    always_comb begin
        res_out = '0;
        case (reg_write_mux_ctrl)
            WB_PC1:  res_out = XLEN'(pc_inc);
            WB_MEM:  res_out = dmem_rdata;
            WB_ALU:  res_out = alu_res_out;
            default: res_out = '0;
        endcase
    end

    always_comb begin
        wr_addr = rs;
        case (reg_write)
            RW_RT:   wr_addr = rt;
            RW_R31:  wr_addr = 5'd31;
            default: wr_addr = rs;
        endcase
    end

    // Carry only tracks adds that actually retire into a register.
    assign carry_d = (alu_op == ALU_ADD && reg_write != RW_NONE)
                     ? alu_carry : carry_q;

    always_comb begin
        pc_d = pc_inc;
        case (br_op)
            BR_B, BR_BL: pc_d = IAW'(instr_out[25:0]);
            BR_BR:       pc_d = IAW'(rs_data);
            BR_BLTZ:     if (rs_data[XLEN-1]) pc_d = IAW'(instr_out[15:0]);
            BR_BZ:       if (rs_data == '0) pc_d = IAW'(instr_out[15:0]);
            BR_BNZ:      if (rs_data != '0) pc_d = IAW'(instr_out[15:0]);
            BR_BCY:      if (carry_q) pc_d = IAW'(instr_out[25:0]);
            BR_BNCY:     if (!carry_q) pc_d = IAW'(instr_out[25:0]);
            default:     pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            carry_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            carry_q <= carry_d;
            if (reg_write != RW_NONE) rf_q[wr_addr] <= res_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && dmem_enable && dmem_write_enable)
            dmem_q[dmem_addr] <= rt_data;
    end

endmodule

// File: tb/tb_kgp_data_path.sv
// Scoreboard bench for kgp_data_path acting as the external control unit.
// Expected values follow DP_VAR_SHIFT_EN when it is defined.
module tb_kgp_data_path;
    import kgp_pkg::*;

    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h01;
    localparam logic [5:0] OP_LW = 6'h10, OP_SW = 6'h11;
    localparam logic [5:0] OP_BR = 6'h21, OP_BLTZ = 6'h22;
    localparam logic [5:0] OP_BZ = 6'h23, OP_BNZ = 6'h24;
    localparam logic [5:0] OP_BL = 6'h25, OP_BCY = 6'h26;
    localparam logic [5:0] OP_BNCY = 6'h27;
    localparam logic [5:0] F_ADD = 6'd1, F_COMP = 6'd2, F_XOR = 6'd4;
    localparam int S_INS = 0, S_ALU = 1, S_RES = 2, S_IMM = 3, S_OPF = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  reg_write, reg_write_mux_ctrl;
    logic        imm_mux_ctrl, alu_mux_ctrl;
    logic [3:0]  alu_op;
    logic        dmem_enable, dmem_write_enable;
    logic [4:0]  br_op;
    logic [31:0] instr_out, res_out, alu_res_out, imm_res_out;
    logic [5:0]  opcode_out, func_out;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    kgp_data_path dut (
        .clk                (clk),
        .rst                (rst),
        .reg_write          (reg_write),
        .imm_mux_ctrl       (imm_mux_ctrl),
        .alu_mux_ctrl       (alu_mux_ctrl),
        .alu_op             (alu_op),
        .dmem_enable        (dmem_enable),
        .dmem_write_enable  (dmem_write_enable),
        .reg_write_mux_ctrl (reg_write_mux_ctrl),
        .br_op              (br_op),
        .instr_out          (instr_out),
        .opcode_out         (opcode_out),
        .func_out           (func_out),
        .res_out            (res_out),
        .alu_res_out        (alu_res_out),
        .imm_res_out        (imm_res_out)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] op,
        input logic [4:0] rs, rt, sh, input logic [5:0] fn);
        return {op, rs, rt, sh, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op,
        input logic [4:0] rs, input logic [20:0] imm);
        return {op, rs, imm};
    endfunction

    function automatic logic [31:0] mtype(input logic [5:0] op,
        input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op,
        input logic [25:0] a);
        return {op, a};
    endfunction

    task automatic rom(input int a, input logic [31:0] w);
        dut.imem[a] = w;
    endtask

    task automatic push(input string tag, input int sel,
                        input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic ctl(input logic [1:0] rw, input logic im, am,
        input logic [3:0] op, input logic de, we,
        input logic [1:0] wb, input logic [4:0] br);
        reg_write          = rw;
        imm_mux_ctrl       = im;
        alu_mux_ctrl       = am;
        alu_op             = op;
        dmem_enable        = de;
        dmem_write_enable  = we;
        reg_write_mux_ctrl = wb;
        br_op              = br;
    endtask

    // Compare everything queued for this instruction, then retire it.
    task automatic step();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_INS:   check(e.tag, instr_out, e.val);
                S_ALU:   check(e.tag, alu_res_out, e.val);
                S_RES:   check(e.tag, res_out, e.val);
                S_IMM:   check(e.tag, imm_res_out, e.val);
                default: check(e.tag, {20'd0, opcode_out, func_out}, e.val);
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] vexp;
        rst = 1'b1;
        ctl(2'd1, 0, 0, 4'd3, 0, 0, 2'd2, 5'd0);
        #1;
        rom(0, rtype(OP_R, 0, 0, 0, F_XOR));
        rom(1, itype(OP_ADDI, 0, 21'd121));
        rom(2, itype(OP_ADDI, 1, 21'd231));
        rom(3, rtype(OP_R, 0, 1, 0, F_ADD));
        rom(4, rtype(OP_R, 0, 0, 0, F_COMP));
        rom(5, rtype(OP_R, 5, 5, 0, F_XOR));
        rom(6, mtype(OP_SW, 5, 0, 16'd0));
        rom(7, mtype(OP_SW, 5, 1, 16'd1));
        rom(8, mtype(OP_LW, 5, 0, 16'd0));
        rom(9, mtype(OP_LW, 5, 1, 16'd1));
        rom(10, rtype(OP_R, 2, 2, 0, F_XOR));
        rom(11, itype(OP_ADDI, 2, 21'h1FFFFF));
        rom(12, itype(OP_ADDI, 2, 21'd1));
        rom(13, jtype(OP_BCY, 26'd40));
        rom(40, jtype(OP_BNCY, 26'd50));
        rom(41, mtype(OP_BZ, 2, 0, 16'd60));
        rom(60, mtype(OP_BNZ, 2, 0, 16'd70));
        rom(61, jtype(OP_BL, 26'd100));
        rom(100, rtype(OP_R, 31, 5, 0, F_ADD));
        rom(101, rtype(OP_BR, 31, 0, 0, 0));
        rom(62, mtype(OP_BLTZ, 0, 0, 16'd80));
        rom(80, mtype(OP_SW, 5, 0, 16'd5));
        rom(81, mtype(OP_SW, 5, 1, 16'd6));
        rom(82, mtype(OP_SW, 5, 1, 16'd5));
        @(posedge clk);
        #1;

        push("rst_instr", S_INS, rtype(OP_R, 0, 0, 0, F_XOR));
        push("rst_res", S_RES, 32'd0);
        step();
        rst = 1'b0;
        push("xor0_res", S_RES, 32'd0);
        step();
        ctl(2'd1, 0, 1, 4'd0, 0, 0, 2'd2, 5'd0);
        push("addi0_res", S_RES, 32'd121);
        step();
        push("addi1_imm", S_IMM, 32'd231);
        push("addi1_res", S_RES, 32'd231);
        step();
        ctl(2'd1, 0, 0, 4'd0, 0, 0, 2'd2, 5'd0);
        push("add_opf", S_OPF, {20'd0, OP_R, F_ADD});
        push("add_alu", S_ALU, 32'd352);
        step();
        ctl(2'd1, 0, 0, 4'd1, 0, 0, 2'd2, 5'd0);
        push("comp_res", S_RES, 32'hFFFF_FEA0);
        step();
        ctl(2'd1, 0, 0, 4'd3, 0, 0, 2'd2, 5'd0);
        step();
        ctl(2'd0, 1, 1, 4'd0, 1, 1, 2'd3, 5'd0);
        push("sw0_alu", S_ALU, 32'd0);
        step();
        push("sw1_alu", S_ALU, 32'd1);
        step();
        ctl(2'd2, 1, 1, 4'd0, 1, 0, 2'd1, 5'd0);
        push("lw0_res", S_RES, 32'hFFFF_FEA0);
        step();
        push("lw1_res", S_RES, 32'd231);
        step();
        ctl(2'd1, 0, 0, 4'd3, 0, 0, 2'd2, 5'd0);
        step();
        ctl(2'd1, 0, 1, 4'd0, 0, 0, 2'd2, 5'd0);
        push("addim1_imm", S_IMM, 32'hFFFF_FFFF);
        push("addim1_alu", S_ALU, 32'hFFFF_FFFF);
        step();
        push("wrap_alu", S_ALU, 32'd0);
        step();
        ctl(2'd0, 0, 0, 4'd0, 0, 0, 2'd3, 5'd7);
        push("bcy_instr", S_INS, jtype(OP_BCY, 26'd40));
        step();
        ctl(2'd0, 0, 0, 4'd0, 0, 0, 2'd3, 5'd8);
        push("bcy_taken", S_INS, jtype(OP_BNCY, 26'd50));
        step();
        ctl(2'd0, 0, 0, 4'd0, 0, 0, 2'd3, 5'd4);
        push("bncy_fall", S_INS, mtype(OP_BZ, 2, 0, 16'd60));
        step();
        ctl(2'd0, 0, 0, 4'd0, 0, 0, 2'd3, 5'd5);
        push("bz_taken", S_INS, mtype(OP_BNZ, 2, 0, 16'd70));
        step();
        ctl(2'd3, 0, 0, 4'd2, 0, 0, 2'd0, 5'd6);
        push("bnz_fall", S_INS, jtype(OP_BL, 26'd100));
        push("bl_res", S_RES, 32'd62);
        step();
        ctl(2'd0, 0, 0, 4'd0, 0, 0, 2'd3, 5'd0);
        push("bl_taken", S_INS, rtype(OP_R, 31, 5, 0, F_ADD));
        push("r31_alu", S_ALU, 32'd62);
        step();
        ctl(2'd0, 0, 0, 4'd0, 0, 0, 2'd3, 5'd2);
        step();
        ctl(2'd0, 0, 0, 4'd0, 0, 0, 2'd3, 5'd3);
        push("br_taken", S_INS, mtype(OP_BLTZ, 0, 0, 16'd80));
        step();
        ctl(2'd0, 1, 1, 4'd0, 1, 1, 2'd3, 5'd0);
        push("bltz_taken", S_INS, mtype(OP_SW, 5, 0, 16'd5));
        step();
        step();
        push("sw_abort_ins", S_INS, mtype(OP_SW, 5, 1, 16'd5));
        rst = 1'b1;
        step();
        rst = 1'b0;

        rom(0, rtype(OP_R, 1, 31, 0, F_ADD));
        rom(1, jtype(OP_BNCY, 26'd8));
        rom(8, mtype(OP_LW, 5, 3, 16'd5));
        rom(9, mtype(OP_LW, 5, 4, 16'd5));
        rom(10, mtype(OP_SW, 5, 3, 16'd6));
        rom(11, mtype(OP_LW, 5, 4, 16'd6));
        rom(12, rtype(OP_R, 3, 0, 4, 6'd5));
        rom(13, rtype(OP_R, 3, 0, 4, 6'd6));
        rom(14, rtype(OP_R, 3, 0, 4, 6'd7));
        rom(15, rtype(OP_R, 3, 4, 0, 6'd8));
        rom(16, rtype(OP_R, 3, 4, 0, 6'd9));

        ctl(2'd0, 0, 0, 4'd0, 0, 0, 2'd2, 5'd0);
        push("rst_pc0", S_INS, rtype(OP_R, 1, 31, 0, F_ADD));
        push("rst_regs", S_ALU, 32'd0);
        step();
        ctl(2'd0, 0, 0, 4'd0, 0, 0, 2'd3, 5'd8);
        step();
        ctl(2'd2, 1, 1, 4'd0, 1, 0, 2'd1, 5'd0);
        push("rst_carry", S_INS, mtype(OP_LW, 5, 3, 16'd5));
        push("abort_nowr", S_RES, 32'hFFFF_FEA0);
        step();
        ctl(2'd0, 1, 1, 4'd0, 0, 0, 2'd1, 5'd0);
        push("rd_gated", S_RES, 32'd0);
        step();
        ctl(2'd0, 1, 1, 4'd0, 0, 1, 2'd3, 5'd0);
        step();
        ctl(2'd2, 1, 1, 4'd0, 1, 0, 2'd1, 5'd0);
        push("wr_gated", S_RES, 32'd231);
        step();
        ctl(2'd0, 0, 0, 4'd4, 0, 0, 2'd2, 5'd0);
        push("shll", S_ALU, 32'hFFFF_EA00);
        step();
        ctl(2'd0, 0, 0, 4'd6, 0, 0, 2'd2, 5'd0);
        push("shra", S_ALU, 32'hFFFF_FFEA);
        step();
        ctl(2'd0, 0, 0, 4'd5, 0, 0, 2'd2, 5'd0);
        push("shrl", S_ALU, 32'h0FFF_FFEA);
        step();
`ifdef DP_VAR_SHIFT_EN
        vexp = 32'hFFFF_5000;
`else
        vexp = 32'd0;
`endif
        ctl(2'd0, 0, 0, 4'd7, 0, 0, 2'd2, 5'd0);
        push("shllv", S_ALU, vexp);
        step();
        ctl(2'd0, 0, 0, 4'd15, 0, 0, 2'd2, 5'd0);
        push("op_undef", S_ALU, 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
